// File: rtl/mux31_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux31_arbiter (with mux31 datapath)
// Brief    : Round-robin arbiter sharing one datapath between three
//            valid/ready/last requesters through a registered 3:1 mux select.
// Revision : 1.0 - initial release
// ============================================================================

module mux31 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (s)
            2'b00:   y = a;
            2'b01:   y = b;
            2'b10:   y = c;
            default: y = '0;
        endcase
    end

endmodule

module mux31_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       in_valid,
    input  logic [2:0]       in_last,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    output logic [2:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [1:0]       out_sel,
    output logic             burst_cut
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);
    localparam logic [1:0] c_sel_idle  = 2'b11;

    state_t           r_state;
    logic [1:0]       r_owner;
    logic [1:0]       r_last_owner;
    logic [1:0]       r_sel;
    logic [3:0]       r_beat_cnt;
    logic             r_burst_cut;

    logic             w_grant;
    logic             w_owner_valid;
    logic             w_owner_last;
    logic             w_beat;
    logic [3:0]       w_cnt_inc;
    logic             w_cap;
    logic             w_release;
    logic [2:0]       w_idle_arb;
    logic [2:0]       w_rel_arb;
    logic [WIDTH-1:0] w_mux_y;

    function automatic logic [1:0] f_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Returns {found, index}: first valid requester after 'prev', wrapping mod 3.
    function automatic logic [2:0] f_arbitrate(input logic [2:0] valid,
                                               input logic [1:0] prev);
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        c0 = f_next(prev);
        c1 = f_next(c0);
        c2 = f_next(c1);
        if (valid[c0])      return {1'b1, c0};
        else if (valid[c1]) return {1'b1, c1};
        else if (valid[c2]) return {1'b1, c2};
        return 3'b000;
    endfunction

    assign w_grant       = (r_state == ST_GRANT);
    assign w_owner_valid = in_valid[r_owner];
    assign w_owner_last  = in_last[r_owner];
    assign w_beat        = w_grant & w_owner_valid & out_ready;
    assign w_cnt_inc     = r_beat_cnt + 4'd1;
    assign w_cap         = (w_cnt_inc == c_max_burst);
    assign w_release     = w_beat & (w_owner_last | w_cap);
    assign w_idle_arb    = f_arbitrate(in_valid, r_last_owner);
    // On release the outgoing owner becomes the new pointer, so it ranks last.
    assign w_rel_arb     = f_arbitrate(in_valid, r_owner);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 2'd0;
            r_last_owner <= 2'd2;
            r_sel        <= c_sel_idle;
            r_beat_cnt   <= 4'd0;
            r_burst_cut  <= 1'b0;
        end else begin
            r_burst_cut <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_idle_arb[2]) begin
                        r_state    <= ST_GRANT;
                        r_owner    <= w_idle_arb[1:0];
                        r_sel      <= w_idle_arb[1:0];
                        r_beat_cnt <= 4'd0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_last_owner <= r_owner;
                        r_burst_cut  <= ~w_owner_last;
                        r_beat_cnt   <= 4'd0;
                        if (w_rel_arb[2]) begin
                            r_owner <= w_rel_arb[1:0];
                            r_sel   <= w_rel_arb[1:0];
                        end else begin
                            r_state <= ST_IDLE;
                            r_sel   <= c_sel_idle;
                        end
                    end else if (w_beat) begin
                        r_beat_cnt <= w_cnt_inc;
                    end
                end
            endcase
        end
    end

    generate
        for (genvar i = 0; i < 3; i++) begin : g_ready
            assign in_ready[i] = w_grant & (r_owner == 2'(i)) & out_ready;
        end
    endgenerate

    assign out_valid = w_grant & w_owner_valid;
    assign out_last  = w_grant & w_owner_last;
    assign out_sel   = r_sel;
    assign burst_cut = r_burst_cut;

    mux31 #(
        .WIDTH (WIDTH)
    ) u_mux31 (
        .a (in_data0),
        .b (in_data1),
        .c (in_data2),
        .s (r_sel),
        .y (w_mux_y)
    );

    assign out_data = (r_sel == c_sel_idle) ? '0 : w_mux_y;

endmodule

`default_nettype wire

// File: tb/tb_mux31_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux31_arbiter
// Brief    : Scenario tasks plus randomized run against a round-robin model,
//            covering MAX_BURST = 4 and MAX_BURST = 1 instances.
// Revision : 1.0 - initial release
// ============================================================================

module tb_mux31_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  in_valid;
    logic [2:0]  in_last;
    logic [31:0] in_data0;
    logic [31:0] in_data1;
    logic [31:0] in_data2;
    logic        out_ready;

    logic [2:0]  in_ready,  in_ready_1;
    logic        out_valid, out_valid_1;
    logic [31:0] out_data,  out_data_1;
    logic        out_last,  out_last_1;
    logic [1:0]  out_sel,   out_sel_1;
    logic        burst_cut, burst_cut_1;

    int n_tests = 0;
    int n_fail  = 0;

    mux31_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .out_sel(out_sel),
        .burst_cut(burst_cut)
    );

    mux31_arbiter #(.WIDTH(32), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2),
        .in_ready(in_ready_1), .out_valid(out_valid_1), .out_data(out_data_1),
        .out_last(out_last_1), .out_ready(out_ready), .out_sel(out_sel_1),
        .burst_cut(burst_cut_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner -1 means no grant; index 0 models dut, 1 models dut1.
    int m_owner [2];
    int m_last  [2];
    int m_beats [2];
    int m_cut   [2];
    int m_max   [2] = '{4, 1};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_last[k]  = 2;
            m_beats[k] = 0;
            m_cut[k]   = 0;
        end
    endtask

    function automatic int pick_after(input int prev);
        for (int n = 1; n <= 3; n++) begin
            int idx;
            idx = (prev + n) % 3;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                int o;
                o = m_owner[k];
                m_cut[k] = 0;
                if (o < 0) begin
                    m_owner[k] = pick_after(m_last[k]);
                    m_beats[k] = 0;
                end else if (in_valid[o] && out_ready) begin
                    m_beats[k] = m_beats[k] + 1;
                    if (in_last[o] || m_beats[k] == m_max[k]) begin
                        m_cut[k]   = in_last[o] ? 0 : 1;
                        m_last[k]  = o;
                        m_owner[k] = pick_after(o);
                        m_beats[k] = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [39:0] model_outputs(input int k);
        int          o;
        logic [1:0]  sel;
        logic        v, l;
        logic [2:0]  rdy;
        logic [31:0] d;
        o   = m_owner[k];
        sel = (o < 0) ? 2'b11 : 2'(o);
        v   = (o >= 0) && in_valid[o];
        l   = (o >= 0) && in_last[o];
        rdy = (o >= 0 && out_ready) ? 3'(1 << o) : 3'b000;
        d   = (o == 0) ? in_data0 : (o == 1) ? in_data1 : (o == 2) ? in_data2 : 32'h0;
        return {sel, v, rdy, l, 1'(m_cut[k]), d};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({out_sel, in_ready, out_valid, burst_cut, out_data} !== {2'b11, 3'b000, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state: sel=%b rdy=%b v=%b cut=%b data=%h, want sel=11 rdy=000 v=0 cut=0 data=0",
                     out_sel, in_ready, out_valid, burst_cut, out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 3'b001; in_last = 3'b001; in_data0 = 32'habcdef12; out_ready = 1'b1;
        #1;
        n_tests++;
        if ({out_sel, in_ready} !== {2'b11, 3'b000}) begin
            n_fail++;
            $display("FAIL single_idle: sel=%b rdy=%b, want 11 000", out_sel, in_ready);
        end
        tick();
        n_tests++;
        if ({out_sel, in_ready, out_valid, out_last, out_data} !== {2'b00, 3'b001, 1'b1, 1'b1, 32'habcdef12}) begin
            n_fail++;
            $display("FAIL single_grant: sel=%b rdy=%b v=%b l=%b data=%h, want 00 001 1 1 abcdef12",
                     out_sel, in_ready, out_valid, out_last, out_data);
        end
        tick();
        // Requester 0 is still the only valid one at release, so it is re-granted.
        n_tests++;
        if (out_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL single_regrant: sel=%b, want 00", out_sel);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_sel  [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
        logic [31:0] exp_data [4] = '{32'habcdef12, 32'h12345678, 32'hbabeface, 32'habcdef12};
        do_reset();
        in_valid = 3'b111; in_last = 3'b111; out_ready = 1'b1;
        in_data0 = 32'habcdef12; in_data1 = 32'h12345678; in_data2 = 32'hbabeface;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if ({out_sel, out_valid, out_data} !== {exp_sel[i], 1'b1, exp_data[i]}) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: sel=%b v=%b data=%h, want %b 1 %h",
                         i, out_sel, out_valid, out_data, exp_sel[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 3'b111; in_last = 3'b111; out_ready = 1'b1;
        in_data0 = 32'habcdef12; in_data1 = 32'h12345678; in_data2 = 32'hbabeface;
        repeat (3) tick();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_tests++;
            if ({out_sel, in_ready, out_valid, out_data} !== {2'b10, 3'b000, 1'b1, 32'hbabeface}) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: sel=%b rdy=%b v=%b data=%h, want 10 000 1 babeface",
                         i, out_sel, in_ready, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 3'b100) begin
            n_fail++;
            $display("FAIL backpressure_ready: rdy=%b, want 100", in_ready);
        end
        tick();
        n_tests++;
        if (out_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL backpressure_next: sel=%b, want 00", out_sel);
        end
    endtask

    task automatic test_burst_cap();
        do_reset();
        in_valid = 3'b011; in_last = 3'b010; out_ready = 1'b1;
        tick();
        for (int b = 1; b <= 4; b++) begin
            n_tests++;
            if ({out_sel, burst_cut} !== {2'b00, 1'b0}) begin
                n_fail++;
                $display("FAIL burst_beat%0d: sel=%b cut=%b, want 00 0", b, out_sel, burst_cut);
            end
            tick();
        end
        n_tests++;
        if ({out_sel, burst_cut} !== {2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL burst_cut: sel=%b cut=%b, want 01 1", out_sel, burst_cut);
        end
        tick();
        n_tests++;
        if ({out_sel, burst_cut} !== {2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL burst_resume5: sel=%b cut=%b, want 00 0", out_sel, burst_cut);
        end
        tick();
        in_last = 3'b011;
        #1;
        n_tests++;
        if ({out_sel, out_last} !== {2'b00, 1'b1}) begin
            n_fail++;
            $display("FAIL burst_resume6: sel=%b last=%b, want 00 1", out_sel, out_last);
        end
        tick();
        n_tests++;
        if ({out_sel, burst_cut} !== {2'b01, 1'b0}) begin
            n_fail++;
            $display("FAIL burst_after_last: sel=%b cut=%b, want 01 0", out_sel, burst_cut);
        end
    endtask

    task automatic test_lone_regrant();
        do_reset();
        in_valid = 3'b010; in_last = 3'b010; out_ready = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({out_sel, out_valid, in_ready} !== {2'b01, 1'b1, 3'b010}) begin
            n_fail++;
            $display("FAIL lone_regrant: sel=%b v=%b rdy=%b, want 01 1 010", out_sel, out_valid, in_ready);
        end
        // A fresh count means the cap lands exactly four beats after the re-grant.
        in_last = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++;
            if ({out_sel, burst_cut} !== {2'b01, 1'(i == 4)}) begin
                n_fail++;
                $display("FAIL lone_count[%0d]: sel=%b cut=%b, want 01 %0d", i, out_sel, burst_cut, (i == 4));
            end
        end
    endtask

    task automatic test_max1();
        do_reset();
        in_valid = 3'b001; in_last = 3'b000; out_ready = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({out_sel_1, burst_cut_1, burst_cut} !== {2'b00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL max1_cut: sel1=%b cut1=%b cut=%b, want 00 1 0", out_sel_1, burst_cut_1, burst_cut);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 3'b010; in_last = 3'b000; out_ready = 1'b0; in_data1 = 32'h12345678;
        tick();
        n_tests++;
        if (out_sel !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_mid_owner: sel=%b, want 01", out_sel);
        end
        out_ready = 1'b1;
        rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if ({out_sel, in_ready, out_valid, out_data} !== {2'b11, 3'b000, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_async: sel=%b rdy=%b v=%b data=%h, want 11 000 0 0",
                     out_sel, in_ready, out_valid, out_data);
        end
        tick();
        rst = 1'b0;
        in_valid = 3'b111;
        tick();
        n_tests++;
        if (out_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_first: sel=%b, want 00", out_sel);
        end
    endtask

    task automatic test_random();
        logic [39:0] got;
        logic [39:0] exp;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 2) == 0) in_valid = 3'($urandom_range(0, 7));
            in_last   = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data0  = $urandom;
            in_data1  = $urandom;
            in_data2  = $urandom;
            #1;
            got = {out_sel, out_valid, in_ready, out_last, burst_cut, out_data};
            exp = model_outputs(0);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_max4[%0d]: got %h want %h", cyc, got, exp);
            end
            got = {out_sel_1, out_valid_1, in_ready_1, out_last_1, burst_cut_1, out_data_1};
            exp = model_outputs(1);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_max1[%0d]: got %h want %h", cyc, got, exp);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 3'b000; in_last = 3'b000; out_ready = 1'b0;
        in_data0 = 32'h0; in_data1 = 32'h0; in_data2 = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_burst_cap();
        test_lone_regrant();
        test_max1();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
